// File: rtl/unidade_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : unidade_mult_div
// Brief    : Multi-cycle shift-add multiplier / restoring divider producing
//            the HI/LO pair for MULT, MULTU, DIV and DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt;
  logic               is_div;       // op[1]: divide family
  logic               neg_res;      // product / quotient must be negated
  logic               neg_rem;      // remainder must be negated
  logic               zero_div;     // divisor was zero
  logic [WIDTH-1:0]   raw_a;        // dividend as given, for divide-by-zero
  logic [WIDTH-1:0]   opnd;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;          // {hi_acc, multiplier} or {rem, quo}

  // operand preparation at start
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & operandA[WIDTH-1];
  assign b_neg     = is_signed & operandB[WIDTH-1];
  assign a_mag     = a_neg ? -operandA : operandA;
  assign b_mag     = b_neg ? -operandB : operandB;

  // one iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  // Remainder stays below the divisor, so the shifted remainder minus the
  // divisor always fits a WIDTH+1 bit signed value; bit WIDTH is the borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next  = {(div_trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  // sign fixup and divide-by-zero override for the final write
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (zero_div) begin
        fix_hi = raw_a;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // datapath: latch operands, iterate, write results
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      raw_a    <= '0;
      opnd     <= '0;
      acc      <= '0;
      done     <= 1'b0;
      divZero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt      <= CW'(WIDTH - 1);
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= (operandB == '0);
            raw_a    <= operandA;
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi      <= fix_hi;
          lo      <= fix_lo;
          divZero <= is_div & zero_div;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_mult_div
// Brief    : Self-checking bench for unidade_mult_div (directed + random ops
//            against an arithmetic reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_mult_div;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  unidade_mult_div #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .divZero  (divZero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: {divZero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op; scramble inputs after acceptance; optionally pulse a
  // spurious start at cycle ign_at. Returns cycles to done and busy status.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ign_at, output int lat, output bit busy_ok);
    op = o; operandA = a; operandB = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
    lat = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == ign_at) begin
        start = 1'b1; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
      end
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic do_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int ign_at);
    int          lat;
    bit          bok;
    logic [64:0] exp;
    run_op(o, a, b, ign_at, lat, bok);
    exp = model(o, a, b);
    check($sformatf("%s.latency", tag), 64'(lat), 64'd33);
    check($sformatf("%s.busy_run", tag), {63'd0, bok}, 64'd1);
    check($sformatf("%s.busy_done", tag), {63'd0, busy}, 64'd0);
    check($sformatf("%s.hi", tag), {32'd0, hi}, {32'd0, exp[63:32]});
    check($sformatf("%s.lo", tag), {32'd0, lo}, {32'd0, exp[31:0]});
    check($sformatf("%s.divZero", tag), {63'd0, divZero}, {63'd0, exp[64]});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    bit          saw_done;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.done", {63'd0, done}, 64'd0);
    check("rst.divZero", {63'd0, divZero}, 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // directed cases (back-to-back: each start lands in the previous done cycle)
    do_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max.hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
    check("multu_max.lo_const", {32'd0, lo}, 64'h0000_0001);
    do_check("mult_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, -1);
    do_check("mult_min2", 2'd0, 32'h8000_0000, 32'h8000_0000, -1);
    do_check("div_neg7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    do_check("divu_100_7", 2'd3, 32'd100, 32'd7, -1);
    do_check("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_min_m1.lo_const", {32'd0, lo}, 64'h8000_0000);
    do_check("divu_by0", 2'd3, 32'd5, 32'd0, -1);
    check("divu_by0.dz_const", {63'd0, divZero}, 64'd1);
    do_check("multu_2x3", 2'd1, 32'd2, 32'd3, -1);
    do_check("div_by0_signed", 2'd2, 32'hFFFF_FF00, 32'd0, -1);
    do_check("mult_ignored_start", 2'd0, 32'd12345, 32'hFFFF_E57B, 10);

    // results hold while idle
    repeat (5) @(posedge clock);
    #1;
    check("hold.done", {63'd0, done}, 64'd0);
    check("hold.hilo", {hi, lo}, model(2'd0, 32'd12345, 32'hFFFF_E57B) & 65'h0_FFFF_FFFF_FFFF_FFFF);

    // random operations against the model
    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_check($sformatf("rand%0d", i), ro, ra, rb, -1);
    end

    // make sure hi/lo are non-zero before the abort test
    do_check("pre_abort", 2'd1, 32'd1000, 32'd77, -1);

    // asynchronous reset in the middle of a divide
    op = 2'd2; operandA = 32'hFFFF_FFF9; operandB = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort.busy", {63'd0, busy}, 64'd0);
    check("abort.done", {63'd0, done}, 64'd0);
    check("abort.hilo", {hi, lo}, 64'd0);
    #3;
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort.no_done", {63'd0, saw_done}, 64'd0);
    check("abort.idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
